int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 21 ++
 rtl/int_prio_enc.sv | 20 ++
 rtl/int_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map
// offsets and the "no source" index.
package int_ctrl_pkg;

  localparam int          NSRC  = 6;
  localparam logic [2:0]  NO_ID = 3'd7;

  // Register offsets as decoded from addr[3:2]
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Encodings are visible to software through the CTRL register
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: returns the index of the lowest set request bit,
// or NO_ID when no bit is set.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NSRC-1:0] req_i,
  output logic [2:0]      idx_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    idx_o = NO_ID;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Six-source interrupt controller with per-source mask and edge/level mode,
// fixed lowest-index-first priority and a single in-service slot closed by
// an EOI write to CTRL.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [5:0]  src,
  input  logic        irq_ack,
  output logic        irq,
  output logic [2:0]  irq_id
);

  logic [NSRC-1:0] mask_q, mode_q, pend_q, pend_d, src_q;
  logic [NSRC-1:0] rise, pend_clr, ack_clr, cand;
  logic [2:0]      winner, irq_id_q, insvc_q;
  logic            irq_q, ack_fire, eoi;
  logic            wr_mask, wr_pend, wr_mode, wr_ctrl;
  state_e          state_q;

  // Only addr[3:2] and din[5:0] carry meaning; the rest is deliberately ignored
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], din[31:6]};

  assign wr_mask = we && (addr[3:2] == REG_MASK);
  assign wr_pend = we && (addr[3:2] == REG_PEND);
  assign wr_mode = we && (addr[3:2] == REG_MODE);
  assign wr_ctrl = we && (addr[3:2] == REG_CTRL);

  assign rise     = src & ~src_q;
  assign ack_fire = (state_q == REQ) && irq_ack;
  assign eoi      = (state_q == SERV) && wr_ctrl && din[0];
  // The acknowledged source is the one currently presented on irq_id
  assign ack_clr  = ack_fire ? (NSRC'(1) << irq_id_q) : '0;
  assign pend_clr = (wr_pend ? din[NSRC-1:0] : '0) | ack_clr;
  assign cand     = pend_q & mask_q;

  int_prio_enc u_prio (
    .req_i (cand),
    .idx_o (winner)
  );

  // Pending next state: level bits follow src, edge bits set on a rise
  // (which beats any clear) and otherwise clear on W1C or acknowledge
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (!mode_q[i])       pend_d[i] = src[i];
      else if (rise[i])     pend_d[i] = 1'b1;
      else if (pend_clr[i]) pend_d[i] = 1'b0;
    end
  end

  // Software-visible registers and the source history used for edge detect
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      src_q  <= '0;
    end else begin
      if (wr_mask) mask_q <= din[NSRC-1:0];
      if (wr_mode) mode_q <= din[NSRC-1:0];
      pend_q <= pend_d;
      src_q  <= src;
    end
  end

  // Request/service FSM with registered irq, irq_id and in-service index
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= NO_ID;
      insvc_q  <= NO_ID;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand != '0) begin
            state_q  <= REQ;
            irq_q    <= 1'b1;
            irq_id_q <= winner;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q  <= SERV;
            irq_q    <= 1'b0;
            irq_id_q <= NO_ID;
            insvc_q  <= irq_id_q;
          end else if (cand == '0) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= NO_ID;
          end else begin
            irq_id_q <= winner;
          end
        end
        SERV: begin
          if (eoi) begin
            state_q <= IDLE;
            insvc_q <= NO_ID;
          end
        end
        default: begin
          state_q  <= IDLE;
          irq_q    <= 1'b0;
          irq_id_q <= NO_ID;
          insvc_q  <= NO_ID;
        end
      endcase
    end
  end

  // Side-effect-free read mux
  always_comb begin
    dout = '0;
    case (addr[3:2])
      REG_MASK: dout = {26'd0, mask_q};
      REG_PEND: dout = {26'd0, pend_q};
      REG_MODE: dout = {26'd0, mode_q};
      REG_CTRL: dout = {26'd0, state_q, 1'b0, insvc_q};
      default:  dout = '0;
    endcase
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

endmodule
